// File: rtl/lc3b_types.sv
// Shared LC-3b memory-hierarchy types: word, cache line, and the L2 arbiter's
// state and selection encodings.
package lc3b_types;

   typedef logic [15:0]  lc3b_word;
   typedef logic [127:0] lc3b_cache_line;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BUSY_I = 2'd1,
      BUSY_D = 2'd2,
      DONE   = 2'd3
   } lc3b_arb_state;

   typedef enum logic {
      ARB_I = 1'b0,
      ARB_D = 1'b1
   } lc3b_arb_sel;

   function automatic lc3b_arb_sel other_side(input lc3b_arb_sel s);
      if (s == ARB_I) begin
         return ARB_D;
      end else begin
         return ARB_I;
      end
   endfunction

endpackage

// File: rtl/l2_arbiter_checker.sv
// Simulation-only protocol checks on the L1 request inputs of the L2 arbiter.
module l2_arbiter_checker (
   input logic clk,
   input logic rst_n,
   input logic d_mem_read_i,
   input logic d_mem_write_i
);

   // The D-cache must never request a read and a writeback at once.
   a_d_rw_exclusive: assert property (@(posedge clk) disable iff (!rst_n)
      !(d_mem_read_i && d_mem_write_i));

endmodule

// File: rtl/l2_arbiter_grant.sv
// Winner selection between I and D requests, with the last-grant and
// starvation-count history that the selection depends on.
module l2_arbiter_grant
   import lc3b_types::*;
#(
   parameter bit          D_PRIORITY = 1'b0,
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_req_i,
   input  logic        d_req_i,
   input  logic        grant_i,
   output lc3b_arb_sel win_o
);

   localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

   lc3b_arb_sel last_q, last_d;
   logic [3:0]  starve_q, starve_d;
   lc3b_arb_sel win_s;

   // Pick the winner from the live requests and the arbitration history.
   always_comb begin
      win_s = ARB_I;
      if (i_req_i && d_req_i) begin
         if (D_PRIORITY != 1'b0) begin
            if (starve_q == STARVE_LIM) begin
               win_s = ARB_I;
            end else begin
               win_s = ARB_D;
            end
         end else begin
            win_s = other_side(last_q);
         end
      end else if (d_req_i) begin
         win_s = ARB_D;
      end else begin
         win_s = ARB_I;
      end
   end

   // History only moves on an actual grant; starvation counts I losses.
   always_comb begin
      last_d   = last_q;
      starve_d = starve_q;
      if (grant_i) begin
         last_d = win_s;
         if (win_s == ARB_I) begin
            starve_d = 4'd0;
         end else if (i_req_i && (starve_q != STARVE_LIM)) begin
            starve_d = starve_q + 4'd1;
         end else begin
            starve_d = starve_q;
         end
      end else begin
         last_d   = last_q;
         starve_d = starve_q;
      end
   end

   // History registers; last grant resets to I so D wins the first tie.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_q   <= ARB_I;
         starve_q <= 4'd0;
      end else begin
         last_q   <= last_d;
         starve_q <= starve_d;
      end
   end

   assign win_o = win_s;

endmodule

// File: rtl/l2_arbiter.sv
// Shares the single L2 port between the I-cache (read-only) and the D-cache
// (read/write); one transaction at a time, request latched for its duration.
module l2_arbiter
   import lc3b_types::*;
#(
   parameter bit          D_PRIORITY = 1'b0,
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   input  lc3b_word       i_mem_address,
   input  logic           i_mem_read,
   output lc3b_cache_line i_mem_rdata,
   output logic           i_mem_resp,
   input  lc3b_word       d_mem_address,
   input  logic           d_mem_read,
   input  logic           d_mem_write,
   input  lc3b_cache_line d_mem_wdata,
   output lc3b_cache_line d_mem_rdata,
   output logic           d_mem_resp,
   output lc3b_word       l2arb_mem_address,
   output logic           l2arb_mem_read,
   output logic           l2arb_mem_write,
   output lc3b_cache_line l2arb_mem_wdata,
   input  lc3b_cache_line l2arb_mem_rdata,
   input  logic           l2arb_mem_resp
);

   lc3b_arb_state  state_q;
   lc3b_word       addr_q;
   lc3b_cache_line wdata_q;
   logic           rd_q, wr_q;

   logic        i_req_s, d_req_s, grant_s;
   lc3b_arb_sel win_s;

   assign i_req_s = i_mem_read;
   assign d_req_s = d_mem_read | d_mem_write;
   assign grant_s = (state_q == IDLE) && (i_req_s || d_req_s);

   l2_arbiter_grant #(
      .D_PRIORITY (D_PRIORITY),
      .STARVE_MAX (STARVE_MAX)
   ) u_grant (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_req_i (i_req_s),
      .d_req_i (d_req_s),
      .grant_i (grant_s),
      .win_o   (win_s)
   );

   l2_arbiter_checker u_chk (
      .clk           (clk),
      .rst_n         (rst_n),
      .d_mem_read_i  (d_mem_read),
      .d_mem_write_i (d_mem_write)
   );

   // Transaction FSM; L2 request lines come only from these registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         addr_q  <= 16'h0000;
         wdata_q <= 128'd0;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (grant_s) begin
                  if (win_s == ARB_D) begin
                     state_q <= BUSY_D;
                     addr_q  <= d_mem_address;
                     wdata_q <= d_mem_wdata;
                     wr_q    <= d_mem_write;
                     rd_q    <= ~d_mem_write;
                  end else begin
                     state_q <= BUSY_I;
                     addr_q  <= i_mem_address;
                     wdata_q <= 128'd0;
                     rd_q    <= 1'b1;
                     wr_q    <= 1'b0;
                  end
               end
            end
            BUSY_I, BUSY_D: begin
               if (l2arb_mem_resp) begin
                  rd_q    <= 1'b0;
                  wr_q    <= 1'b0;
                  state_q <= DONE;
               end
            end
            DONE: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign l2arb_mem_address = addr_q;
   assign l2arb_mem_read    = rd_q;
   assign l2arb_mem_write   = wr_q;
   assign l2arb_mem_wdata   = wdata_q;

   // Completion reaches only the owner, in the same cycle L2 signals it.
   assign i_mem_resp  = (state_q == BUSY_I) && l2arb_mem_resp;
   assign d_mem_resp  = (state_q == BUSY_D) && l2arb_mem_resp;
   assign i_mem_rdata = l2arb_mem_rdata;
   assign d_mem_rdata = l2arb_mem_rdata;

endmodule

// File: tb/tb_l2_arbiter.sv
// Bench for l2_arbiter: a round-robin and a D-priority instance, each checked
// every cycle against a transaction-level model, plus directed scenarios.
module tb_l2_arbiter;

   localparam int SMAX = 4;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic [1:0][15:0]  i_addr, d_addr, l2_addr;
   logic [1:0]        i_rd, d_rd, d_wr, i_resp, d_resp, l2_rd, l2_wr, l2_resp;
   logic [1:0][127:0] i_rdata, d_rdata, d_wdata, l2_wdata, l2_rdata;

   l2_arbiter #(.D_PRIORITY(1'b0), .STARVE_MAX(SMAX)) dut0 (
      .clk(clk), .rst_n(rst_n),
      .i_mem_address(i_addr[0]), .i_mem_read(i_rd[0]),
      .i_mem_rdata(i_rdata[0]), .i_mem_resp(i_resp[0]),
      .d_mem_address(d_addr[0]), .d_mem_read(d_rd[0]), .d_mem_write(d_wr[0]),
      .d_mem_wdata(d_wdata[0]), .d_mem_rdata(d_rdata[0]), .d_mem_resp(d_resp[0]),
      .l2arb_mem_address(l2_addr[0]), .l2arb_mem_read(l2_rd[0]),
      .l2arb_mem_write(l2_wr[0]), .l2arb_mem_wdata(l2_wdata[0]),
      .l2arb_mem_rdata(l2_rdata[0]), .l2arb_mem_resp(l2_resp[0]));

   l2_arbiter #(.D_PRIORITY(1'b1), .STARVE_MAX(SMAX)) dut1 (
      .clk(clk), .rst_n(rst_n),
      .i_mem_address(i_addr[1]), .i_mem_read(i_rd[1]),
      .i_mem_rdata(i_rdata[1]), .i_mem_resp(i_resp[1]),
      .d_mem_address(d_addr[1]), .d_mem_read(d_rd[1]), .d_mem_write(d_wr[1]),
      .d_mem_wdata(d_wdata[1]), .d_mem_rdata(d_rdata[1]), .d_mem_resp(d_resp[1]),
      .l2arb_mem_address(l2_addr[1]), .l2arb_mem_read(l2_rd[1]),
      .l2arb_mem_write(l2_wr[1]), .l2arb_mem_wdata(l2_wdata[1]),
      .l2arb_mem_rdata(l2_rdata[1]), .l2arb_mem_resp(l2_resp[1]));

   int n_checks = 0;
   int n_err    = 0;

   task automatic chk(input string nm, input int k, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL dut%0d %s: got %h expected %h", k, nm, act, exp);
      end
   endtask

   // ---------------- behavioural model (transaction level) ----------------
   // phase: 0 idle, 1 L2 busy, 2 one turnaround cycle; owner: 0 = I, 1 = D
   int             m_ph[2], m_own[2], m_prev[2], m_loss[2];
   logic           m_wr[2];
   logic [15:0]    m_addr[2];
   logic [127:0]   m_wd[2];

   function automatic int pick(input int k, input logic ireq, input logic dreq);
      if (ireq && dreq) begin
         if (k == 0) return 1 - m_prev[k];
         return (m_loss[k] >= SMAX) ? 0 : 1;
      end
      return dreq ? 1 : 0;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < 2; k++) begin
            m_ph[k] <= 0; m_own[k] <= 0; m_prev[k] <= 0; m_loss[k] <= 0;
            m_wr[k] <= 1'b0; m_addr[k] <= 16'h0000; m_wd[k] <= 128'd0;
         end
      end else begin
         for (int k = 0; k < 2; k++) begin
            if (m_ph[k] == 0 && (i_rd[k] || d_rd[k] || d_wr[k])) begin
               m_ph[k]   <= 1;
               m_own[k]  <= pick(k, i_rd[k], d_rd[k] | d_wr[k]);
               m_prev[k] <= pick(k, i_rd[k], d_rd[k] | d_wr[k]);
               if (pick(k, i_rd[k], d_rd[k] | d_wr[k]) == 0) m_loss[k] <= 0;
               else if (i_rd[k]) m_loss[k] <= (m_loss[k] + 1 > SMAX) ? SMAX : m_loss[k] + 1;
               m_addr[k] <= (pick(k, i_rd[k], d_rd[k] | d_wr[k]) == 1) ? d_addr[k] : i_addr[k];
               m_wr[k]   <= (pick(k, i_rd[k], d_rd[k] | d_wr[k]) == 1) ? d_wr[k] : 1'b0;
               m_wd[k]   <= (pick(k, i_rd[k], d_rd[k] | d_wr[k]) == 1) ? d_wdata[k] : 128'd0;
            end else if (m_ph[k] == 1) begin
               if (l2_resp[k]) m_ph[k] <= 2;
            end else if (m_ph[k] == 2) begin
               m_ph[k] <= 0;
            end
         end
      end
   end

   // ---------------- per-cycle comparison ----------------
   always @(negedge clk) begin
      for (int k = 0; k < 2; k++) begin
         chk("l2_read",  k, l2_rd[k], (m_ph[k] == 1) && !m_wr[k]);
         chk("l2_write", k, l2_wr[k], (m_ph[k] == 1) && m_wr[k]);
         chk("i_resp",   k, i_resp[k], (m_ph[k] == 1) && (m_own[k] == 0) && l2_resp[k]);
         chk("d_resp",   k, d_resp[k], (m_ph[k] == 1) && (m_own[k] == 1) && l2_resp[k]);
         chk("i_rdata",  k, i_rdata[k], l2_rdata[k]);
         chk("d_rdata",  k, d_rdata[k], l2_rdata[k]);
         if (m_ph[k] == 1) begin
            chk("l2_addr", k, l2_addr[k], m_addr[k]);
            if (m_own[k] == 0 || m_wr[k]) chk("l2_wdata", k, l2_wdata[k], m_wd[k]);
         end
      end
   end

   // ---------------- L1 / L2 environment ----------------
   logic [1:0] got_i, got_d, was_busy, spur;
   int lat[2], wcnt[2], n_iresp[2], n_dresp[2];
   bit rand_lat;
   int glog0[$], glog1[$];

   task automatic step();
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         got_i[k] = i_resp[k];
         got_d[k] = d_resp[k];
         if (i_resp[k]) n_iresp[k]++;
         if (d_resp[k]) n_dresp[k]++;
      end
      @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
         if (got_i[k]) i_rd[k] = 1'b0;
         if (got_d[k]) begin d_rd[k] = 1'b0; d_wr[k] = 1'b0; end
         if ((l2_rd[k] || l2_wr[k]) && !was_busy[k]) begin
            if (k == 0) glog0.push_back(int'(l2_wr[k]));
            else        glog1.push_back(int'(l2_wr[k]));
         end
         was_busy[k] = l2_rd[k] | l2_wr[k];
         l2_rdata[k] = {$urandom, $urandom, $urandom, $urandom};
         if (l2_resp[k]) begin
            l2_resp[k] = 1'b0;
         end else if (spur[k]) begin
            l2_resp[k] = 1'b1;
            spur[k]    = 1'b0;
         end else if (l2_rd[k] || l2_wr[k]) begin
            wcnt[k]++;
            if (wcnt[k] >= lat[k]) begin
               l2_resp[k] = 1'b1;
               wcnt[k]    = 0;
               if (rand_lat) lat[k] = $urandom_range(1, 4);
            end
         end
      end
   endtask

   task automatic run_until_idle(input int k, input string nm);
      int n = 0;
      while ((i_rd[k] || d_rd[k] || d_wr[k]) && n < 80) begin
         step();
         n++;
      end
      chk({nm, "_served"}, k, {i_rd[k], d_rd[k], d_wr[k]}, 3'b000);
   endtask

   int bi, bd, n;

   initial begin
      rst_n = 1'b0;
      i_rd = 2'b00; d_rd = 2'b00; d_wr = 2'b00; l2_resp = 2'b00; spur = 2'b00;
      i_addr = '0; d_addr = '0; d_wdata = '0; l2_rdata = '0;
      was_busy = 2'b00; got_i = 2'b00; got_d = 2'b00;
      lat[0] = 3; lat[1] = 3; wcnt[0] = 0; wcnt[1] = 0;
      n_iresp[0] = 0; n_iresp[1] = 0; n_dresp[0] = 0; n_dresp[1] = 0;
      rand_lat = 1'b0;
      repeat (3) step();
      for (int k = 0; k < 2; k++) begin
         chk("rst_read",  k, l2_rd[k], 1'b0);
         chk("rst_write", k, l2_wr[k], 1'b0);
         chk("rst_addr",  k, l2_addr[k], 16'h0000);
         chk("rst_wdata", k, l2_wdata[k], 128'd0);
         chk("rst_resp",  k, {i_resp[k], d_resp[k]}, 2'b00);
      end
      rst_n = 1'b1;
      step(); step();

      // Lone I read, L2 answers after 5 cycles.
      lat[0] = 5; i_addr[0] = 16'h1230; i_rd[0] = 1'b1;
      bi = n_iresp[0]; bd = n_dresp[0];
      step();
      chk("t1_addr", 0, l2_addr[0], 16'h1230);
      chk("t1_read", 0, l2_rd[0], 1'b1);
      run_until_idle(0, "t1");
      chk("t1_done_read", 0, l2_rd[0], 1'b0);
      step(); step();
      chk("t1_iresp_count", 0, n_iresp[0] - bi, 1);
      chk("t1_dresp_count", 0, n_dresp[0] - bd, 0);

      // Four I/D conflicts under round-robin; D changes inputs mid-transaction.
      glog0.delete(); lat[0] = 3;
      for (int r = 0; r < 4; r++) begin
         i_addr[0] = 16'h0100; i_rd[0] = 1'b1;
         d_addr[0] = 16'h2200; d_wdata[0] = {16{8'hA5}}; d_wr[0] = 1'b1;
         step();
         if (r == 0) begin
            chk("t2_addr",  0, l2_addr[0], 16'h2200);
            chk("t2_write", 0, l2_wr[0], 1'b1);
            chk("t2_wdata", 0, l2_wdata[0], {16{8'hA5}});
            d_addr[0] = 16'hBEEF; d_wdata[0] = {$urandom, $urandom, $urandom, $urandom};
            step();
            chk("t2_hold_addr",  0, l2_addr[0], 16'h2200);
            chk("t2_hold_wdata", 0, l2_wdata[0], {16{8'hA5}});
         end
         run_until_idle(0, "t2");
         step();
      end
      chk("t2_grants", 0, glog0.size(), 8);
      for (int i = 0; i < glog0.size(); i++) chk("t2_grant_order", 0, glog0[i], (i % 2 == 0) ? 1 : 0);

      // D-priority with I waiting: I forced in on every fifth arbitration.
      glog1.delete(); lat[1] = 2;
      i_addr[1] = 16'h0500; d_addr[1] = 16'h3300; d_wdata[1] = {4{32'h1357_9BDF}};
      i_rd[1] = 1'b1; d_wr[1] = 1'b1;
      n = 0;
      while (glog1.size() < 10 && n < 300) begin
         step();
         i_rd[1] = 1'b1; d_wr[1] = 1'b1;
         n++;
      end
      i_rd[1] = 1'b0; d_wr[1] = 1'b0;
      repeat (8) step();
      chk("t3_grants", 1, (glog1.size() >= 10), 1'b1);
      for (int i = 0; i < 10 && i < glog1.size(); i++)
         chk("t3_grant_order", 1, glog1[i], (i % 5 == 4) ? 0 : 1);

      // Reset during a D transaction with I pending.
      lat[1] = 8; d_addr[1] = 16'h4400; d_wr[1] = 1'b1; i_addr[1] = 16'h0440; i_rd[1] = 1'b1;
      step();
      chk("t4_busy_write", 1, l2_wr[1], 1'b1);
      chk("t4_busy_addr",  1, l2_addr[1], 16'h4400);
      step(); step();
      bi = n_iresp[1]; bd = n_dresp[1];
      rst_n = 1'b0; d_wr[1] = 1'b0;
      #1;
      chk("t4_rst_write", 1, l2_wr[1], 1'b0);
      chk("t4_rst_read",  1, l2_rd[1], 1'b0);
      chk("t4_rst_addr",  1, l2_addr[1], 16'h0000);
      chk("t4_rst_wdata", 1, l2_wdata[1], 128'd0);
      l2_resp = 2'b00; wcnt[0] = 0; wcnt[1] = 0; was_busy = 2'b00;
      step();
      rst_n = 1'b1; lat[1] = 3;
      step();
      chk("t4_i_addr", 1, l2_addr[1], 16'h0440);
      chk("t4_i_read", 1, l2_rd[1], 1'b1);
      run_until_idle(1, "t4");
      step(); step();
      chk("t4_stale_dresp", 1, n_dresp[1] - bd, 0);
      chk("t4_iresp_count", 1, n_iresp[1] - bi, 1);

      // Spurious L2 response while idle.
      bi = n_iresp[0]; bd = n_dresp[0];
      spur[0] = 1'b1;
      step(); step(); step();
      chk("t5_iresp", 0, n_iresp[0] - bi, 0);
      chk("t5_dresp", 0, n_dresp[0] - bd, 0);
      chk("t5_read",  0, l2_rd[0], 1'b0);

      // Randomised traffic on both instances.
      rand_lat = 1'b1;
      for (int c = 0; c < 3000; c++) begin
         for (int k = 0; k < 2; k++) begin
            if (!i_rd[k] && $urandom_range(0, 3) == 0) begin
               i_rd[k] = 1'b1; i_addr[k] = 16'($urandom);
            end
            if (!(d_rd[k] || d_wr[k]) && $urandom_range(0, 3) == 0) begin
               d_addr[k] = 16'($urandom);
               d_wdata[k] = {$urandom, $urandom, $urandom, $urandom};
               if ($urandom_range(0, 1) == 1) d_wr[k] = 1'b1;
               else                           d_rd[k] = 1'b1;
            end
            if ($urandom_range(0, 7) == 0) begin
               d_addr[k]  = 16'($urandom);
               d_wdata[k] = {$urandom, $urandom, $urandom, $urandom};
               i_addr[k]  = 16'($urandom);
            end
            if (!(l2_rd[k] || l2_wr[k]) && !l2_resp[k] && $urandom_range(0, 31) == 0) spur[k] = 1'b1;
         end
         step();
      end
      rand_lat = 1'b0;
      i_rd = 2'b00; d_rd = 2'b00; d_wr = 2'b00;
      repeat (20) step();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
